// File: rtl/inv_key_schedule.sv
// Reverse AES-256 key schedule: loads round keys 13/14 and emits round keys 14..0, one per cycle.
// Optional macro INVKS_OUTREG_EN adds one register stage on rk_out/rk_round/rk_valid/done.

module sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, inv;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] keyup_in,
  input  logic [127:0] keylo_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e       state_q, state_d;
  logic [127:0] a_q, a_d, b_q, b_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [31:0]  a3, rot, sub_in, sub_out, g_word;
  logic [31:0]  b0, b1, b2, b3;
  logic [7:0]   rcon;
  logic [127:0] new_key;

  assign a3  = a_q[31:0];
  assign rot = {a3[23:0], a3[31:24]};
  // The round being generated is q = cnt-2, so q has the same parity as cnt.
  assign sub_in = cnt_q[0] ? a3 : rot;

  for (genvar i = 0; i < 4; i++) begin : g_sub
    sbox u_sbox (.din(sub_in[8*i +: 8]), .dout(sub_out[8*i +: 8]));
  end

  always_comb begin
    case (cnt_q)
      4'd2:    rcon = 8'h01;
      4'd4:    rcon = 8'h02;
      4'd6:    rcon = 8'h04;
      4'd8:    rcon = 8'h08;
      4'd10:   rcon = 8'h10;
      4'd12:   rcon = 8'h20;
      4'd14:   rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  assign g_word  = sub_out ^ {rcon, 24'h000000};
  assign b0      = b_q[127:96];
  assign b1      = b_q[95:64];
  assign b2      = b_q[63:32];
  assign b3      = b_q[31:0];
  assign new_key = {b0 ^ g_word, b1 ^ b0, b2 ^ b1, b3 ^ b2};

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = keyup_in;
          b_d     = keylo_in;
          cnt_d   = 4'd14;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d = new_key;
        // B and cnt freeze on round 0 so rk_out/rk_round keep the last emitted key.
        if (cnt_q == 4'd0) begin
          state_d = FIN;
        end else begin
          b_d   = a_q;
          cnt_d = cnt_q - 4'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef INVKS_OUTREG_EN
  logic [127:0] rk_out_q;
  logic [3:0]   rk_round_q;
  logic         rk_valid_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out_q   <= '0;
      rk_round_q <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rk_out_q   <= b_q;
      rk_round_q <= cnt_q;
      rk_valid_q <= (state_q == RUN);
      done_q     <= (state_q == FIN);
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_round = rk_round_q;
  assign rk_valid = rk_valid_q;
  assign done     = done_q;
  // FIN is the cycle in which round 0 leaves the output register.
  assign busy     = (state_q != IDLE);
`else
  assign rk_out   = b_q;
  assign rk_round = cnt_q;
  assign rk_valid = (state_q == RUN);
  assign done     = (state_q == FIN);
  assign busy     = (state_q == RUN);
`endif

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: forward AES-256 expansion model feeds rounds 13/14
// and checks the emitted reverse sequence, reset, abort and ignored-start behaviour.

module tb_inv_key_schedule;
`ifdef INVKS_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] keyup_in, keylo_in, rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid, busy, done;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_rk [0:14];
  logic [127:0] got    [0:14];

  inv_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .keyup_in(keyup_in), .keylo_in(keylo_in),
    .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX_TAB[2047 - 8*int'(x[8*i +: 8]) -: 8];
    return r;
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Starts a run with exp_rk[13]/[14], checks every emitted key; optionally re-pulses start.
  task automatic run_seq(input string tag, input int poke_round,
                         input logic [127:0] poke_up, input logic [127:0] poke_lo);
    keyup_in = exp_rk[13];
    keylo_in = exp_rk[14];
    start    = 1'b1;
    step();
    start    = 1'b0;
    keyup_in = ~exp_rk[13];
    keylo_in = ~exp_rk[14];
    for (int k = 1; k < LAT; k++) begin
      check($sformatf("%s_lat_valid", tag), 128'(rk_valid), 128'(1'b0));
      step();
    end
    for (int r = 14; r >= 0; r--) begin
      check($sformatf("%s_valid_r%0d", tag, r), 128'(rk_valid), 128'(1'b1));
      check($sformatf("%s_round_r%0d", tag, r), 128'(rk_round), 128'(r));
      check($sformatf("%s_key_r%0d", tag, r), rk_out, exp_rk[r]);
      if (r == 14) check($sformatf("%s_busy", tag), 128'(busy), 128'(1'b1));
      got[r] = rk_out;
      if (r == poke_round) begin
        start    = 1'b1;
        keyup_in = poke_up;
        keylo_in = poke_lo;
      end
      step();
      start = 1'b0;
    end
    check($sformatf("%s_done", tag), 128'(done), 128'(1'b1));
    check($sformatf("%s_valid_end", tag), 128'(rk_valid), 128'(1'b0));
    step();
    check($sformatf("%s_done_pulse", tag), 128'(done), 128'(1'b0));
    check($sformatf("%s_busy_end", tag), 128'(busy), 128'(1'b0));
    check($sformatf("%s_valid_after", tag), 128'(rk_valid), 128'(1'b0));
  endtask

  initial begin
    logic timed_out;
    rst      = 1'b1;
    start    = 1'b0;
    keyup_in = '0;
    keylo_in = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 128'(rk_valid), 128'(1'b0));
    check("rst_busy", 128'(busy), 128'(1'b0));
    check("rst_done", 128'(done), 128'(1'b0));
    check("rst_out", rk_out, 128'h0);
    check("rst_round", 128'(rk_round), 128'h0);
    step();

    // Key 000102..1f: last two round keys are the original key halves.
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    run_seq("seq", -1, '0, '0);
    check("seq_r1_hand", got[1], 128'h101112131415161718191a1b1c1d1e1f);
    check("seq_r0_hand", got[0], 128'h000102030405060708090a0b0c0d0e0f);

    expand(256'h0);
    run_seq("zero", -1, '0, '0);
    check("zero_r3_hand", got[3], {4{32'haafbfbfb}});
    check("zero_r2_hand", got[2], {4{32'h62636363}});
    check("zero_r1_hand", got[1], 128'h0);
    check("zero_r0_hand", got[0], 128'h0);

    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run_seq("rand", -1, '0, '0);

    // Abort with rst once round 7 is on the output.
    keyup_in  = exp_rk[13];
    keylo_in  = exp_rk[14];
    start     = 1'b1;
    step();
    start     = 1'b0;
    timed_out = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rk_valid && rk_round == 4'd7) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    check("abort_reach_r7", 128'(timed_out), 128'(1'b0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 128'(rk_valid), 128'(1'b0));
    check("abort_busy", 128'(busy), 128'(1'b0));
    check("abort_done", 128'(done), 128'(1'b0));
    check("abort_out", rk_out, 128'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_quiet_valid", 128'(rk_valid), 128'(1'b0));
      check("abort_quiet_done", 128'(done), 128'(1'b0));
    end
    run_seq("restart", -1, '0, '0);

    // A second start at round 10 with other keys must not disturb the run.
    expand(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_seq("poke", 10, {4{32'hdeadbeef}}, {4{32'h01234567}});
    for (int k = 0; k < 3; k++) begin
      check("poke_quiet_valid", 128'(rk_valid), 128'(1'b0));
      step();
    end

    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rststart_valid", 128'(rk_valid), 128'(1'b0));
      check("rststart_busy", 128'(busy), 128'(1'b0));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
